// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl
// Run/pause/stop sequencer for an external 4-bit up/down counter. A base
// prescaler divides i_clk_1 into base ticks. An optional slow prescaler
// divides the base ticks further. The FSM turns the resulting step events
// into single-cycle enables for the counter datapath.
//
// Optional feature: define AUTO_REVERSE_EN to make the counter ping-pong
// between 0 and 15 instead of wrapping.
//
// Parameters
//   TICK_DIV   i_clk_1 cycles per base tick (2 .. 2^27-1)
//   SLOW_MULT  base ticks per count step in slow mode (2 .. 15)
//
// Ports
//   i_clk_1        system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        pulse: begin counting, or resume from pause
//   i_stop         pulse: pause while running, abort while paused
//   i_clr_req      pulse: clear the counter and return to idle
//   i_dir          requested direction (0 up, 1 down), sampled on a fresh start
//   i_slow         0: step every base tick, 1: step every SLOW_MULT base ticks
//   i_stop_at_tgt  enables stopping when i_cnt_val equals i_target
//   i_target       stop value
//   i_cnt_val      live counter value fed back from the datapath
//   o_cnt_en       single-cycle step enable to the counter
//   o_cnt_dir      direction to the counter
//   o_cnt_clr      single-cycle synchronous clear to the counter
//   o_busy         high while running
//   o_done         high while the target has been reached
//   o_state        IDLE=00, RUN=01, PAUSE=10, DONE=11
module count_seq_ctrl #(
  parameter int TICK_DIV  = 100000000,
  parameter int SLOW_MULT = 4
) (
  input  logic       i_clk_1,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_clr_req,
  input  logic       i_dir,
  input  logic       i_slow,
  input  logic       i_stop_at_tgt,
  input  logic [3:0] i_target,
  input  logic [3:0] i_cnt_val,
  output logic       o_cnt_en,
  output logic       o_cnt_dir,
  output logic       o_cnt_clr,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_state
);

  localparam int BASE_W = $clog2(TICK_DIV);
  localparam logic [BASE_W-1:0] BASE_LAST = BASE_W'(TICK_DIV - 1);
  localparam logic [3:0]        SLOW_LAST = 4'(SLOW_MULT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  state_t            r_state;
  logic [BASE_W-1:0] r_base_cnt;
  logic [3:0]        r_slow_cnt;
  logic              r_cnt_en;
  logic              r_cnt_dir;
  logic              r_cnt_clr;
  logic              r_busy;
  logic              r_done;

  state_t            w_state_nxt;
  logic [BASE_W-1:0] w_base_nxt;
  logic [3:0]        w_slow_nxt;
  logic              w_cnt_en_nxt;
  logic              w_cnt_dir_nxt;
  logic              w_cnt_clr_nxt;
  logic              w_tick;
  logic              w_match;
  logic              w_step;

  // State and output registers. Every output is taken straight from a flop,
  // so busy/done are registered copies of the next state rather than decodes.
  always_ff @(posedge i_clk_1 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_base_cnt <= '0;
      r_slow_cnt <= '0;
      r_cnt_en   <= 1'b0;
      r_cnt_dir  <= 1'b0;
      r_cnt_clr  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_base_cnt <= w_base_nxt;
      r_slow_cnt <= w_slow_nxt;
      r_cnt_en   <= w_cnt_en_nxt;
      r_cnt_dir  <= w_cnt_dir_nxt;
      r_cnt_clr  <= w_cnt_clr_nxt;
      r_busy     <= (w_state_nxt == ST_RUN);
      r_done     <= (w_state_nxt == ST_DONE);
    end
  end

  // Next-state logic. The if/else chain encodes the per-cycle priority:
  // clear, then stop, then start, then target match, then the prescaler tick.
  // A start while already running is meaningless. It falls through so that
  // it does not mask a target match or a tick.
  always_comb begin
    w_state_nxt   = r_state;
    w_base_nxt    = r_base_cnt;
    w_slow_nxt    = r_slow_cnt;
    w_cnt_en_nxt  = 1'b0;
    w_cnt_dir_nxt = r_cnt_dir;
    w_cnt_clr_nxt = 1'b0;
    w_step        = 1'b0;
    w_tick        = (r_base_cnt == BASE_LAST);
    w_match       = i_stop_at_tgt && (i_cnt_val == i_target);

    if (i_clr_req) begin
      w_state_nxt   = ST_IDLE;
      w_base_nxt    = '0;
      w_slow_nxt    = '0;
      w_cnt_clr_nxt = 1'b1;
    end else if (i_stop) begin
      // Pausing keeps both prescalers so a resume continues mid-period.
      if (r_state == ST_RUN) begin
        w_state_nxt = ST_PAUSE;
      end else if (r_state == ST_PAUSE) begin
        w_state_nxt = ST_IDLE;
        w_base_nxt  = '0;
        w_slow_nxt  = '0;
      end
    end else if (i_start && (r_state != ST_RUN)) begin
      w_state_nxt = ST_RUN;
      // Only a fresh start samples the direction and restarts the period.
      // DONE restarts like IDLE but leaves the counter value alone.
      if (r_state != ST_PAUSE) begin
        w_cnt_dir_nxt = i_dir;
        w_base_nxt    = '0;
        w_slow_nxt    = '0;
      end
    end else if (r_state == ST_RUN) begin
      if (w_match) begin
        w_state_nxt = ST_DONE;
      end else if (w_tick) begin
        w_base_nxt = '0;
        // slow is examined only on a base tick. A mode change therefore
        // lands on a tick boundary and never adds or drops a pulse there.
        if (!i_slow) begin
          w_slow_nxt = '0;
          w_step     = 1'b1;
        end else if (r_slow_cnt == SLOW_LAST) begin
          w_slow_nxt = '0;
          w_step     = 1'b1;
        end else begin
          w_slow_nxt = r_slow_cnt + 4'd1;
        end
      end else begin
        w_base_nxt = r_base_cnt + BASE_W'(1);
      end
    end

    if (w_step) begin
      w_cnt_en_nxt = 1'b1;
`ifdef AUTO_REVERSE_EN
      // Turn around at the end stops on the same cycle the enable goes out.
      // The counter then moves back inward instead of wrapping.
      if (!r_cnt_dir && (i_cnt_val == 4'd15)) begin
        w_cnt_dir_nxt = 1'b1;
      end else if (r_cnt_dir && (i_cnt_val == 4'd0)) begin
        w_cnt_dir_nxt = 1'b0;
      end
`else
      w_cnt_dir_nxt = r_cnt_dir;
`endif
    end
  end

  assign o_cnt_en  = r_cnt_en;
  assign o_cnt_dir = r_cnt_dir;
  assign o_cnt_clr = r_cnt_clr;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_state   = r_state;

endmodule

// File: doc/count_seq_ctrl.md
COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, clk_1 cycles per base tick (legal range 2 to 2^27-1).
REQ-002 SHALL have parameter SLOW_MULT, default 4, base ticks per count step in slow mode (legal range 2 to 15).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk_1  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 start  in  1  single-cycle pulse; begin or resume counting.
REQ-007 stop  in  1  single-cycle pulse; pause, or abort when paused.
REQ-008 clr_req  in  1  single-cycle pulse; clear counter and return to IDLE.
REQ-009 dir  in  1  requested direction, 0 up, 1 down.
REQ-010 slow  in  1  0 step every base tick, 1 step every SLOW_MULT base ticks.
REQ-011 stop_at_tgt  in  1  1 enables the target-stop function.
REQ-012 target  in  4  stop value for the counter.
REQ-013 cnt_val  in  4  live value fed back from the 4-bit counter datapath.
REQ-014 cnt_en  out  1  single-cycle step enable to the counter.
REQ-015 cnt_dir  out  1  direction to the counter, 0 up, 1 down.
REQ-016 cnt_clr  out  1  single-cycle synchronous clear to the counter.
REQ-017 busy  out  1  high while in RUN.
REQ-018 done  out  1  high while in DONE.
REQ-019 state  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

Function
REQ-020 All outputs SHALL be registered.
REQ-021 FSM per-cycle priority SHALL be clr_req > stop > start > target match > tick; with start and stop both high, stop wins.
REQ-022 clr_req in any state: cnt_clr high for one cycle, state IDLE, both prescalers zeroed, cnt_en low.
REQ-023 IDLE + start: RUN, cnt_dir loaded from dir, both prescalers zeroed.
REQ-024 DONE + start: behaves as IDLE + start; counter value is not cleared.
REQ-025 RUN + stop: PAUSE, both prescalers held.
REQ-026 PAUSE + start: RUN, prescalers resume from held values, cnt_dir unchanged.
REQ-027 PAUSE + stop: IDLE, prescalers zeroed.
REQ-028 dir SHALL be sampled only when entering RUN from IDLE or DONE.
REQ-029 Base prescaler SHALL count 0..TICK_DIV-1 in RUN only; base tick is the wrap cycle.
REQ-030 slow=0: cnt_en high for the one cycle following each base tick; the first pulse occurs in the TICK_DIV-th... (RUN cycle TICK_DIV+1 counting the entry cycle as 1).
REQ-031 slow=1: slow prescaler counts base ticks 0..SLOW_MULT-1; cnt_en follows only the base tick on which it wraps; slow prescaler is held at 0 while slow=0.
REQ-032 Changes of slow SHALL take effect at the next base tick, with no extra or lost pulse on that tick.
REQ-033 RUN + stop_at_tgt=1 + cnt_val==target (checked every cycle): DONE next cycle, no cnt_en issued that cycle, including the case where the match holds on RUN entry.
REQ-034 cnt_en SHALL never be high outside RUN, and never on two consecutive cycles.
REQ-035 Without auto-reverse, cnt_dir SHALL stay constant through RUN; the counter wraps 15->0 and 0->15.

Reset
REQ-036 rst low SHALL asynchronously force state IDLE; cnt_en, cnt_clr, busy, done and cnt_dir to 0; both prescalers to 0.
REQ-037 Release of rst SHALL be synchronous to clk_1; the first FSM action occurs on the first rising edge with rst high.
REQ-038 Reset mid-RUN SHALL drop any pending tick; no cnt_en is emitted after release until a new start is given.

Configuration
REQ-039 Macro AUTO_REVERSE_EN defined: on the cycle a cnt_en is issued, if cnt_dir=0 and cnt_val=15, cnt_dir flips to 1 on that same cycle; if cnt_dir=1 and cnt_val=0, cnt_dir flips to 0. This gives a ping-pong count without wrap.
REQ-040 AUTO_REVERSE_EN undefined: no reversal logic is compiled; REQ-035 applies.

Verification (TICK_DIV=4, SLOW_MULT=4)
REQ-041 Sequence: reset, then start with dir=0 and slow=0. Required: cnt_en pulses every 4 cycles with cnt_dir=0; busy=1; state=01.
REQ-042 Sequence: slow=1, then run 32 cycles. Required: exactly 2 cnt_en pulses, spaced 16 cycles apart.
REQ-043 Sequence: stop after 2 cycles of a period, wait 10 cycles, then start. Required: the next cnt_en arrives 2 cycles after resume; state goes 01->10->01.
REQ-044 Sequence: stop_at_tgt=1, target=3, cnt_val stepping from 0 upward. Required: no cnt_en after cnt_val=3; done=1; state=11.
REQ-045 Sequence (AUTO_REVERSE_EN): cnt_val=15 with dir up at a tick. Required: cnt_en with cnt_dir=1. Without the macro, the same tick gives cnt_dir=0.
REQ-046 Sequence: clr_req and start together in RUN, then rst low mid-period. Required: cnt_clr 1-cycle pulse and state=00; after reset, outputs are 0 and no cnt_en appears.
